// File: rtl/ssp_pkg.sv
// ============================================================================
// ssp_pkg : shared state encoding and default data width for ssp_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ssp_pkg;

    localparam int SSP_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } ssp_state_e;

    // Round-robin pointer value after channel idx has been served.
    function automatic logic rr_next_ptr(input logic idx);
        return ~idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssp_arbiter_if.sv
// ============================================================================
// ssp_arbiter_if : requester, return-stream and SSP APB-side signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface ssp_arbiter_if import ssp_pkg::*; #(
    parameter int DATA_W = SSP_DATA_W
) ();

    logic              REQ0;
    logic [DATA_W-1:0] DATA0;
    logic              GNT0;
    logic              REQ1;
    logic [DATA_W-1:0] DATA1;
    logic              GNT1;
    logic              PSEL;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              SSPTXINTR;
    logic              SSPRXINTR;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_VALID;

    // Arbiter side.
    modport master (
        input  REQ0, DATA0, REQ1, DATA1, PRDATA, SSPTXINTR, SSPRXINTR,
        output GNT0, GNT1, PSEL, PWRITE, PWDATA, RX_DATA, RX_VALID
    );

    // Requesters / SSP / consumer side.
    modport slave (
        output REQ0, DATA0, REQ1, DATA1, PRDATA, SSPTXINTR, SSPRXINTR,
        input  GNT0, GNT1, PSEL, PWRITE, PWDATA, RX_DATA, RX_VALID
    );

endinterface

`default_nettype wire

// File: rtl/ssp_rr_arb2.sv
// ============================================================================
// ssp_rr_arb2 : 2-way round-robin grant select with update-on-grant pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module ssp_rr_arb2 import ssp_pkg::*; (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] i_req,
    input  wire logic       i_update,
    output logic      [1:0] o_gnt,
    output logic            o_gnt_idx
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        o_gnt_idx = 1'b0;
        o_gnt     = 2'b00;
        ptr_d     = ptr_q;
        // The pointer only matters on contention; a lone requester always wins.
        if (i_req[0] && i_req[1]) begin
            o_gnt_idx = ptr_q;
        end else if (i_req[1]) begin
            o_gnt_idx = 1'b1;
        end
        if (i_req != 2'b00) begin
            o_gnt = o_gnt_idx ? 2'b10 : 2'b01;
        end
        if (i_update && (i_req != 2'b00)) begin
            ptr_d = rr_next_ptr(o_gnt_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ssp_arbiter.sv
// ============================================================================
// ssp_arbiter : shares one SSP write port between two requesters and drains
//               the SSP RX FIFO; optional counters under SSP_ARBITER_STATS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ssp_arbiter import ssp_pkg::*; #(
    parameter int DATA_W  = SSP_DATA_W,
    parameter bit RX_PRIO = 1'b1
`ifdef SSP_ARBITER_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  wire logic        PCLK,
    input  wire logic        CLEAR_B,
    ssp_arbiter_if.master    bus
`ifdef SSP_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] TX_CNT0,
    output logic [CNT_W-1:0] TX_CNT1,
    output logic [CNT_W-1:0] RX_CNT
`endif
);

    ssp_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic       w_drain;
    logic       w_wr_ok;
    logic       w_decide;
    logic       w_take_write;
    logic [1:0] w_arb_gnt;
    logic       w_arb_idx;

    assign w_drain = bus.SSPRXINTR;
    assign w_wr_ok = (bus.REQ0 | bus.REQ1) & ~bus.SSPTXINTR;

    ssp_rr_arb2 u_arb (
        .clk       (PCLK),
        .rst_n     (CLEAR_B),
        .i_req     ({bus.REQ1, bus.REQ0}),
        .i_update  (w_take_write),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        psel_d       = 1'b0;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        w_decide     = 1'b0;
        w_take_write = 1'b0;

        // HOLD lasts one cycle and returns to IDLE, so its closing edge is
        // also the IDLE decision edge; this gives one byte per two cycles.
        case (state_q)
            ST_IDLE:    w_decide = 1'b1;
            ST_HOLD:    w_decide = 1'b1;
            ST_WRITE:   state_d  = ST_HOLD;
            ST_READ: begin
                state_d    = ST_CAPTURE;
                rx_data_d  = bus.PRDATA;
                rx_valid_d = 1'b1;
            end
            ST_CAPTURE: state_d  = ST_IDLE;
            default:    state_d  = ST_IDLE;
        endcase

        if (w_decide) begin
            state_d = ST_IDLE;
            if (w_drain && (RX_PRIO || !w_wr_ok)) begin
                state_d  = ST_READ;
                psel_d   = 1'b1;
                pwrite_d = 1'b0;
            end else if (w_wr_ok) begin
                state_d      = ST_WRITE;
                psel_d       = 1'b1;
                pwrite_d     = 1'b1;
                pwdata_d     = w_arb_idx ? bus.DATA1 : bus.DATA0;
                gnt0_d       = w_arb_gnt[0];
                gnt1_d       = w_arb_gnt[1];
                w_take_write = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            state_q    <= ST_IDLE;
            psel_q     <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.PSEL     = psel_q;
    assign bus.PWRITE   = pwrite_q;
    assign bus.PWDATA   = pwdata_q;
    assign bus.GNT0     = gnt0_q;
    assign bus.GNT1     = gnt1_q;
    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_VALID = rx_valid_q;

`ifdef SSP_ARBITER_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_one = 1;

    logic [CNT_W-1:0] tx_cnt0_q, tx_cnt0_d;
    logic [CNT_W-1:0] tx_cnt1_q, tx_cnt1_d;
    logic [CNT_W-1:0] rx_cnt_q,  rx_cnt_d;

    // Counters step together with the registered pulses they count.
    always_comb begin
        tx_cnt0_d = tx_cnt0_q;
        tx_cnt1_d = tx_cnt1_q;
        rx_cnt_d  = rx_cnt_q;
        if (gnt0_d)     tx_cnt0_d = tx_cnt0_q + c_cnt_one;
        if (gnt1_d)     tx_cnt1_d = tx_cnt1_q + c_cnt_one;
        if (rx_valid_d) rx_cnt_d  = rx_cnt_q  + c_cnt_one;
    end

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            tx_cnt0_q <= '0;
            tx_cnt1_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            tx_cnt0_q <= tx_cnt0_d;
            tx_cnt1_q <= tx_cnt1_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    assign TX_CNT0 = tx_cnt0_q;
    assign TX_CNT1 = tx_cnt1_q;
    assign RX_CNT  = rx_cnt_q;
`endif

endmodule

`default_nettype wire
